// File: rtl/clkctl_pkg.sv
// Shared types and constants for the CPU clock controller: FSM states,
// mode encodings and the reset half-period.
package clkctl_pkg;

  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2
  } clk_state_e;

  localparam logic [1:0] MODE_HALT = 2'b00;
  localparam logic [1:0] MODE_RUN  = 2'b01;
  localparam logic [1:0] MODE_STEP = 2'b10;

  localparam int unsigned CLKCTL_DEFAULT_HALF = 10;

endpackage

// File: rtl/clkctl_step_sync.sv
// Step button front end: 2-flop synchronizer followed by a rising-edge
// detector; step_pulse is high for one clk cycle per press.
module clkctl_step_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic step_i,
  output logic step_pulse
);

  logic [2:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 3'b000;
    end else begin
      sync_q <= {sync_q[1:0], step_i};
    end
  end

  // Edge taken between the second sync flop and its delayed copy.
  assign step_pulse = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/cpu_clock_controller.sv
// CPU clock sequencer: derives c0 from inclk0 in HALT, RUN or single-STEP
// mode with a programmable half-period. STEP support is built only when
// CLKCTL_STEP_EN is defined.
module cpu_clock_controller
  import clkctl_pkg::*;
#(
  parameter int unsigned          BIT_WIDTH    = 32,
  parameter int unsigned          CYC_WIDTH    = 32,
  parameter logic [BIT_WIDTH-1:0] DEFAULT_HALF = BIT_WIDTH'(CLKCTL_DEFAULT_HALF)
) (
  input  logic                 inclk0,
  input  logic                 rst_n,
  input  logic [1:0]           mode,
  input  logic                 step,
  input  logic [BIT_WIDTH-1:0] half_cfg,
  input  logic                 cfg_load,
  output logic                 c0,
  output logic                 running,
  output logic [CYC_WIDTH-1:0] cycle_count
);

  clk_state_e           state_q, state_d;
  logic                 c0_q, c0_d;
  logic                 running_q, running_d;
  logic [BIT_WIDTH-1:0] cnt_q, cnt_d;
  logic [BIT_WIDTH-1:0] half_q, half_d;
  logic [CYC_WIDTH-1:0] cyc_q, cyc_d;
  logic [BIT_WIDTH-1:0] reload;

`ifdef CLKCTL_STEP_EN
  logic step_pulse;

  clkctl_step_sync u_step_sync (
    .clk        (inclk0),
    .rst_n      (rst_n),
    .step_i     (step),
    .step_pulse (step_pulse)
  );
`else
  logic unused_step;
  assign unused_step = step;
`endif

  // Reloads always use the half-period stored before this cycle's cfg_load.
  assign reload = half_q - BIT_WIDTH'(1);

  always_comb begin
    state_d = state_q;
    c0_d    = c0_q;
    cnt_d   = cnt_q;
    half_d  = half_q;
    cyc_d   = cyc_q;

    if (cfg_load) begin
      half_d = (half_cfg == '0) ? BIT_WIDTH'(1) : half_cfg;
    end

    case (state_q)
      ST_HALT: begin
        c0_d = 1'b0;
        if (mode == MODE_RUN) begin
          c0_d    = 1'b1;
          cnt_d   = reload;
          state_d = ST_RUN;
        end
`ifdef CLKCTL_STEP_EN
        else if (mode == MODE_STEP && step_pulse) begin
          c0_d    = 1'b1;
          cnt_d   = reload;
          state_d = ST_STEP;
        end
`endif
      end

      // Leave RUN only once a full low phase has elapsed.
      ST_RUN: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - BIT_WIDTH'(1);
        end else if (c0_q) begin
          c0_d  = 1'b0;
          cnt_d = reload;
        end else if (mode == MODE_RUN) begin
          c0_d  = 1'b1;
          cnt_d = reload;
        end else begin
          state_d = ST_HALT;
        end
      end

`ifdef CLKCTL_STEP_EN
      // One high and one low phase, ignoring mode and further presses.
      ST_STEP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - BIT_WIDTH'(1);
        end else if (c0_q) begin
          c0_d  = 1'b0;
          cnt_d = reload;
        end else begin
          state_d = ST_HALT;
        end
      end
`endif

      default: begin
        c0_d    = 1'b0;
        state_d = ST_HALT;
      end
    endcase

    if (c0_d && !c0_q) begin
      cyc_d = cyc_q + CYC_WIDTH'(1);
    end

    running_d = (state_d != ST_HALT);
  end

  always_ff @(posedge inclk0 or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_HALT;
      c0_q      <= 1'b0;
      running_q <= 1'b0;
      cnt_q     <= '0;
      half_q    <= DEFAULT_HALF;
      cyc_q     <= '0;
    end else begin
      state_q   <= state_d;
      c0_q      <= c0_d;
      running_q <= running_d;
      cnt_q     <= cnt_d;
      half_q    <= half_d;
      cyc_q     <= cyc_d;
    end
  end

  assign c0          = c0_q;
  assign running     = running_q;
  assign cycle_count = cyc_q;

endmodule

// File: tb/tb_cpu_clock_controller.sv
// Self-checking bench for cpu_clock_controller: directed sequences plus a
// per-cycle vector table with hand-computed outputs.
module tb_cpu_clock_controller;

  logic        inclk0 = 1'b0;
  logic        rst_n;
  logic [1:0]  mode;
  logic        step;
  logic [31:0] half_cfg;
  logic        cfg_load;
  logic        c0;
  logic        running;
  logic [31:0] cycle_count;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [1:0]  mode;
    logic        cfg_load;
    logic [31:0] half_cfg;
    logic        exp_c0;
    logic        exp_run;
    logic [31:0] exp_cyc;
  } vec_t;

  vec_t vecs[16];

  cpu_clock_controller dut (
    .inclk0      (inclk0),
    .rst_n       (rst_n),
    .mode        (mode),
    .step        (step),
    .half_cfg    (half_cfg),
    .cfg_load    (cfg_load),
    .c0          (c0),
    .running     (running),
    .cycle_count (cycle_count)
  );

  always #5 inclk0 = ~inclk0;

  task automatic tick();
    @(posedge inclk0);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  initial begin
    // H=1 at table start, state HALT, cycle_count=12.
    vecs[0]  = '{2'b00, 1'b0, 32'd0, 1'b0, 1'b0, 32'd12};
    vecs[1]  = '{2'b01, 1'b0, 32'd0, 1'b1, 1'b1, 32'd13};
    vecs[2]  = '{2'b01, 1'b1, 32'd2, 1'b0, 1'b1, 32'd13};
    vecs[3]  = '{2'b01, 1'b0, 32'd0, 1'b1, 1'b1, 32'd14};
    vecs[4]  = '{2'b01, 1'b0, 32'd0, 1'b1, 1'b1, 32'd14};
    vecs[5]  = '{2'b01, 1'b0, 32'd0, 1'b0, 1'b1, 32'd14};
    vecs[6]  = '{2'b00, 1'b0, 32'd0, 1'b0, 1'b1, 32'd14};
    vecs[7]  = '{2'b00, 1'b0, 32'd0, 1'b0, 1'b0, 32'd14};
    vecs[8]  = '{2'b11, 1'b0, 32'd0, 1'b0, 1'b0, 32'd14};
    vecs[9]  = '{2'b01, 1'b0, 32'd0, 1'b1, 1'b1, 32'd15};
    vecs[10] = '{2'b11, 1'b0, 32'd0, 1'b1, 1'b1, 32'd15};
    vecs[11] = '{2'b11, 1'b0, 32'd0, 1'b0, 1'b1, 32'd15};
    vecs[12] = '{2'b11, 1'b0, 32'd0, 1'b0, 1'b1, 32'd15};
    vecs[13] = '{2'b11, 1'b0, 32'd0, 1'b0, 1'b0, 32'd15};
    vecs[14] = '{2'b10, 1'b0, 32'd0, 1'b0, 1'b0, 32'd15};
    vecs[15] = '{2'b00, 1'b0, 32'd0, 1'b0, 1'b0, 32'd15};

    rst_n    = 1'b0;
    mode     = 2'b00;
    step     = 1'b0;
    half_cfg = 32'd0;
    cfg_load = 1'b0;

    // Reset state
    repeat (3) tick();
    check("reset_c0", 32'(c0), 32'd0);
    check("reset_running", 32'(running), 32'd0);
    check("reset_cycle_count", cycle_count, 32'd0);
    rst_n = 1'b1;
    tick();
    check("idle_c0", 32'(c0), 32'd0);

    // RUN at H=10, then drop to HALT midway through a high phase
    mode = 2'b01;
    for (int j = 0; j <= 104; j++) begin
      tick();
      if (j == 84) mode = 2'b00;
      check("run_c0", 32'((j < 100) && ((j % 20) < 10)), 32'(c0));
      if (j == 80) check("run_cycle_count", cycle_count, 32'd5);
      if (j == 99) check("stop_running_hi", 32'(running), 32'd1);
      if (j == 100) check("stop_running_lo", 32'(running), 32'd0);
    end
    check("stop_cycle_count", cycle_count, 32'd5);

    // Reconfigure mid-phase to 3, then to 0 coincident with a reload
    mode = 2'b01;
    for (int j = 0; j <= 33; j++) begin
      logic e;
      tick();
      cfg_load = 1'b0;
      if (j == 4) begin cfg_load = 1'b1; half_cfg = 32'd3; end
      if (j == 24) begin cfg_load = 1'b1; half_cfg = 32'd0; end
      if (j < 10) e = 1'b1;
      else if (j < 28) e = ((j - 10) % 6) >= 3;
      else e = (j % 2) == 1;
      check("cfg_c0", 32'(c0), 32'(e));
    end
    check("cfg_cycle_count", cycle_count, 32'd12);
    mode = 2'b00;
    tick();
    check("cfg_stop_c0", 32'(c0), 32'd0);
    check("cfg_stop_running_hi", 32'(running), 32'd1);
    tick();
    check("cfg_stop_running_lo", 32'(running), 32'd0);

    // Vector table at H=1 -> 2, including reserved mode 11
    for (int i = 0; i < 16; i++) begin
      mode     = vecs[i].mode;
      cfg_load = vecs[i].cfg_load;
      half_cfg = vecs[i].half_cfg;
      tick();
      check($sformatf("vec%0d_c0", i), 32'(c0), 32'(vecs[i].exp_c0));
      check($sformatf("vec%0d_running", i), 32'(running), 32'(vecs[i].exp_run));
      check($sformatf("vec%0d_cycle_count", i), cycle_count, vecs[i].exp_cyc);
    end
    cfg_load = 1'b0;

`ifdef CLKCTL_STEP_EN
    // Single step at H=4 with a second press during the pulse
    cfg_load = 1'b1;
    half_cfg = 32'd4;
    tick();
    cfg_load = 1'b0;
    mode     = 2'b10;
    step     = 1'b1;
    for (int e = 1; e <= 16; e++) begin
      tick();
      if (e == 4) step = 1'b0;
      if (e == 5) step = 1'b1;
      check("step_c0", 32'(c0), 32'((e >= 3) && (e < 7)));
      check("step_running", 32'(running), 32'((e >= 3) && (e < 11)));
    end
    check("step_cycle_count", cycle_count, 32'd16);
    step = 1'b0;
    mode = 2'b00;
    tick();
`else
    // STEP mode absent: mode 10 with step toggling keeps c0 low
    mode = 2'b10;
    for (int e = 0; e < 16; e++) begin
      step = e[1];
      tick();
      check("nostep_c0", 32'(c0), 32'd0);
      check("nostep_running", 32'(running), 32'd0);
    end
    check("nostep_cycle_count", cycle_count, 32'd15);
    step = 1'b0;
    mode = 2'b00;
    tick();
`endif

    // Asynchronous reset while c0 is high
    mode = 2'b01;
    tick();
    check("prereset_c0", 32'(c0), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_c0", 32'(c0), 32'd0);
    check("async_cycle_count", cycle_count, 32'd0);
    check("async_running", 32'(running), 32'd0);
    mode = 2'b00;
    tick();
    rst_n = 1'b1;
    tick();
    check("postreset_c0", 32'(c0), 32'd0);
    check("postreset_cycle_count", cycle_count, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cpu_clock_controller.md
# cpu_clock_controller

Sequencing front end for the single-cycle CPU clock. It derives the CPU clock `c0` from the board clock and runs it in one of three modes: free-running at a programmable rate, halted low, or single-stepped one full period per button press. It sits between the board oscillator/debug switches and every CPU register that consumes `c0`. It also provides a running indicator and a retired-cycle counter for the debug display.

## Interface
- `BIT_WIDTH`, 32: width of the half-period register and counter.
- `CYC_WIDTH`, 32: width of `cycle_count`.
- `DEFAULT_HALF`, 32'd10: half-period in `inclk0` cycles, loaded at reset.
- `inclk0`  in  1  board clock; all logic is on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `mode`  in  2  00 HALT, 01 RUN, 10 STEP, 11 reserved (treated as HALT); synchronous to `inclk0`.
- `step`  in  1  asynchronous step button level, debounced externally.
- `half_cfg`  in  BIT_WIDTH  new half-period value.
- `cfg_load`  in  1  one-cycle strobe that latches `half_cfg`.
- `c0`  out  1  CPU clock, registered.
- `running`  out  1  high whenever the FSM is not in HALT.
- `cycle_count`  out  CYC_WIDTH  count of `c0` rising edges since reset.

## Operation
- States: HALT, RUN, STEP.
- `half_reg` holds the half-period `H`. `cfg_load` writes `max(half_cfg,1)`, so 0 is stored as 1.
- `cnt` is a down-counter. Each `c0` phase lasts exactly `H` `inclk0` cycles.
- HALT: `c0` = 0.
  - `mode`=RUN: `c0`<=1, `cnt`<=`H-1`, go to RUN.
  - `mode`=STEP and a synchronized rising edge of `step`: `c0`<=1, `cnt`<=`H-1`, go to STEP.
  - Otherwise stay in HALT.
- RUN: `cnt` decrements every cycle. At `cnt`==0:
  - If `c0`=1: `c0`<=0 and reload.
  - If `c0`=0 and `mode`=RUN: `c0`<=1 and reload.
  - If `c0`=0 and `mode`!=RUN: go to HALT with `c0` held at 0.
  - Result: RUN exits only at the end of a complete low phase, never mid-phase.
- STEP: emits exactly one high phase of `H` cycles, then one low phase of `H` cycles, then returns to HALT.
  - `step` edges and `mode` changes during STEP are ignored. The pulse always completes.
- `cycle_count` increments in the cycle in which `c0` is registered 0→1. It wraps modulo 2^CYC_WIDTH.
- `cfg_load` in any state updates `half_reg` immediately. The new `H` is used only at the next reload; the phase in progress keeps its length.
- `cfg_load` coincident with a reload: the reload uses the old `H`.

## Timing
- Reset values: `c0`=0, `running`=0, `cycle_count`=0, `cnt`=0, `half_reg`=`DEFAULT_HALF`, state HALT.
- Reset asserted mid-phase forces `c0` low asynchronously.
- `mode`→RUN is sampled at edge k; `c0` is high after edge k.
- RUN period is `2H` cycles with 50% duty.
- After RUN exits, `c0` stays low for at least `H+1` cycles before any restart.
- `step` passes a 2-flop synchronizer and then an edge detector.
  - If `step` is first sampled high at edge 1, `c0` rises after edge 3.
- `running` is registered and changes on the same edge as the state.

## Configuration
- `CLKCTL_STEP_EN` defined:
  - STEP state, synchronizer and edge detector are present.
- `CLKCTL_STEP_EN` undefined:
  - `mode`=10 behaves as HALT and `step` is ignored.
  - No STEP state or synchronizer logic is built.

## Structure
- `clkctl_pkg` holds:
  - the state enum (HALT, RUN, STEP);
  - mode encodings `MODE_HALT`, `MODE_RUN`, `MODE_STEP`;
  - the default half-period constant.
- Sub-module `clkctl_step_sync`: 2-flop synchronizer plus rising-edge detector with output `step_pulse`. It is reset by `rst_n` to all zeros.

## Test plan
- **Reset and RUN:** release reset, hold `mode`=01 with `H`=10. Expect `c0` high after the next edge, then period 20 with 50% duty, and `cycle_count`=5 after 5 rising edges.
- **Stop at boundary:** in RUN, drop `mode` to 00 midway through a high phase. Expect the high phase to complete (10 cycles) and the low phase to complete (10 cycles), then `c0` held low and `running`=0.
- **Reconfigure:** pulse `cfg_load` with `half_cfg`=3 midway through a 10-cycle phase. Expect that phase to stay 10 cycles and later phases to be 3 cycles. `half_cfg`=0 yields 1-cycle phases.
- **Single step:** with `mode`=10 and `H`=4, press `step` once. Expect `c0` high 4 and low 4 cycles, rising after edge 3 of the press, with `cycle_count`+1. A second press during the pulse produces no extra pulse.
- **Async reset:** assert `rst_n`=0 while `c0`=1. Expect `c0`=0 and `cycle_count`=0 immediately, without waiting for a clock edge.
- **Macro off:** build without `CLKCTL_STEP_EN`, set `mode`=10 and toggle `step`. Expect `c0` to stay 0.
